// File: rtl/v810_bus_slave.sv
// v810 external-bus responder: decodes CPU bus cycles in its address window, forwards them
// to a variable-latency memory over req/ack, and returns READYN/read data to the CPU.
module v810_bus_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0700_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFF00_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [31:0] a_i,
    input  logic [31:0] d_wr_i,
    output logic [31:0] d_rd_o,
    output logic        d_rd_oe_o,
    input  logic [3:0]  ben_i,
    input  logic [1:0]  st_i,
    input  logic        dan_i,
    input  logic        mrqn_i,
    input  logic        bcystn_i,
    input  logic        rw_i,
    output logic        readyn_o,
    output logic [29:0] mem_a_o,
    output logic [3:0]  mem_ben_o,
    output logic [1:0]  mem_st_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, T2WAIT, ACCESS, DONE, RDY} state_e;

    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] mem_a_q, mem_a_d;
    logic [3:0]  mem_ben_q, mem_ben_d;
    logic [1:0]  mem_st_q, mem_st_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] d_rd_q, d_rd_d;
    logic        d_rd_oe_q, d_rd_oe_d;
    logic        readyn_q, readyn_d;
    logic        start_valid;
    logic        accept;

    // A new cycle may only start from IDLE or in the RDY tick (back-to-back).
    assign start_valid = ce_i && !bcystn_i && !mrqn_i && !dan_i &&
                         ((a_i & ADDR_MASK) == BASE_ADDR);
    assign accept      = start_valid && (state_q == IDLE || state_q == RDY);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_a_d     = mem_a_q;
        mem_ben_d   = mem_ben_q;
        mem_st_d    = mem_st_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_req_d   = mem_req_q;
        d_rd_d      = d_rd_q;
        d_rd_oe_d   = d_rd_oe_q;
        readyn_d    = readyn_q;

        case (state_q)
            IDLE: ;
            T2WAIT: begin
                if (ce_i) begin
                    if (mem_we_q) begin
                        mem_wdata_d = d_wr_i;
                    end
                    if (cnt_q == 4'd0) begin
                        mem_req_d = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            // The memory handshake runs on every clock edge, independent of the CPU clock enable.
            ACCESS: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        d_rd_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ce_i) begin
                    readyn_d  = 1'b0;
                    d_rd_oe_d = !mem_we_q;
                    state_d   = RDY;
                end
            end
            RDY: begin
                if (ce_i) begin
                    readyn_d  = 1'b1;
                    d_rd_oe_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            mem_a_d   = a_i[31:2];
            mem_ben_d = ben_i;
            mem_st_d  = st_i;
            mem_we_d  = !rw_i;
            cnt_d     = WaitInit;
            state_d   = T2WAIT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mem_a_q     <= 30'd0;
            mem_ben_q   <= 4'd0;
            mem_st_q    <= 2'd0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_req_q   <= 1'b0;
            d_rd_q      <= 32'd0;
            d_rd_oe_q   <= 1'b0;
            readyn_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_a_q     <= mem_a_d;
            mem_ben_q   <= mem_ben_d;
            mem_st_q    <= mem_st_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_req_q   <= mem_req_d;
            d_rd_q      <= d_rd_d;
            d_rd_oe_q   <= d_rd_oe_d;
            readyn_q    <= readyn_d;
        end
    end

    assign d_rd_o      = d_rd_q;
    assign d_rd_oe_o   = d_rd_oe_q;
    assign readyn_o    = readyn_q;
    assign mem_a_o     = mem_a_q;
    assign mem_ben_o   = mem_ben_q;
    assign mem_st_o    = mem_st_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_req_o   = mem_req_q;

endmodule

// File: tb/tb_v810_bus_slave.sv
// Bench for v810_bus_slave: two instances share one CPU bus (WAIT_STATES 0 and 2); expected
// accesses are queued when a cycle is driven and checked when the memory request / READYN appear.
module tb_v810_bus_slave;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] a;
    logic [31:0] dWr;
    logic [3:0]  ben;
    logic [1:0]  st;
    logic        dan;
    logic        mrqn;
    logic        bcystn;
    logic        rw;
    logic [1:0]  ack;
    logic [31:0] rData;

    logic [31:0] dRd [2];
    logic [1:0]  oeV;
    logic [1:0]  readynV;
    logic [29:0] memA [2];
    logic [3:0]  memBen [2];
    logic [1:0]  memSt [2];
    logic [1:0]  memWeV;
    logic [31:0] memWdata [2];
    logic [1:0]  memReqV;

    typedef struct {
        logic [29:0] memA;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic [1:0]  st;
        logic [31:0] rdata;
        int          start;
        int          reqLat;
        int          readyLat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int   vectors = 0;
    int   miscompares = 0;
    int   edgeNo = 0;
    logic ceToggle = 1'b0;
    logic ceAtEdge = 1'b0;

    v810_bus_slave #(.BASE_ADDR(32'h0700_0000), .ADDR_MASK(32'hFF00_0000), .WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .a_i(a), .d_wr_i(dWr),
        .d_rd_o(dRd[0]), .d_rd_oe_o(oeV[0]), .ben_i(ben), .st_i(st),
        .dan_i(dan), .mrqn_i(mrqn), .bcystn_i(bcystn), .rw_i(rw),
        .readyn_o(readynV[0]), .mem_a_o(memA[0]), .mem_ben_o(memBen[0]),
        .mem_st_o(memSt[0]), .mem_we_o(memWeV[0]), .mem_wdata_o(memWdata[0]),
        .mem_req_o(memReqV[0]), .mem_ack_i(ack[0]), .mem_rdata_i(rData)
    );

    v810_bus_slave #(.BASE_ADDR(32'h0800_0000), .ADDR_MASK(32'hFF00_0000), .WAIT_STATES(2)) u1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .a_i(a), .d_wr_i(dWr),
        .d_rd_o(dRd[1]), .d_rd_oe_o(oeV[1]), .ben_i(ben), .st_i(st),
        .dan_i(dan), .mrqn_i(mrqn), .bcystn_i(bcystn), .rw_i(rw),
        .readyn_o(readynV[1]), .mem_a_o(memA[1]), .mem_ben_o(memBen[1]),
        .mem_st_o(memSt[1]), .mem_we_o(memWeV[1]), .mem_wdata_o(memWdata[1]),
        .mem_req_o(memReqV[1]), .mem_ack_i(ack[1]), .mem_rdata_i(rData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rwIn, input logic [31:0] wdata,
                                 input logic [3:0] benIn, input logic [1:0] stIn, input logic mrqnIn);
        a      = addr;
        rw     = rwIn;
        dWr    = wdata;
        ben    = benIn;
        st     = stIn;
        bcystn = 1'b0;
        mrqn   = mrqnIn;
        dan    = 1'b0;
    endtask

    task automatic idleBus();
        bcystn = 1'b1;
        mrqn   = 1'b1;
        dan    = 1'b1;
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic stepEdge();
        ceAtEdge = ce;
        @(posedge clk);
        #1;
        edgeNo++;
        if (ceToggle) ce = ~ce;
    endtask

    task automatic pushExpect(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic [3:0] benIn, input logic [1:0] stIn,
                              input logic [31:0] rdata, input int reqLat, input int readyLat);
        exp_t e;
        e.memA     = addr[31:2];
        e.we       = we;
        e.wdata    = wdata;
        e.ben      = benIn;
        e.st       = stIn;
        e.rdata    = rdata;
        e.start    = edgeNo + 1;
        e.reqLat   = reqLat;
        e.readyLat = readyLat;
        sb.push_back(e);
    endtask

    task automatic expectReq(input int inst, input int budget);
        int n = 0;
        while (memReqV[inst] !== 1'b1 && n < budget) begin
            stepEdge();
            n++;
        end
        checkOutput("memReqRise", {31'd0, memReqV[inst]}, 32'd1);
        checkOutput("sbHasEntry", {31'd0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checkOutput("reqLatency", edgeNo - cur.start, cur.reqLat);
            checkOutput("memA", {2'b00, memA[inst]}, {2'b00, cur.memA});
            checkOutput("memWe", {31'd0, memWeV[inst]}, {31'd0, cur.we});
            checkOutput("memBen", {28'd0, memBen[inst]}, {28'd0, cur.ben});
            checkOutput("memSt", {30'd0, memSt[inst]}, {30'd0, cur.st});
            if (cur.we) checkOutput("memWdata", memWdata[inst], cur.wdata);
        end
    endtask

    task automatic expectReadyLow(input int inst, input int budget);
        int n = 0;
        while (readynV[inst] !== 1'b0 && n < budget) begin
            stepEdge();
            n++;
        end
        checkOutput("readynLow", {31'd0, readynV[inst]}, 32'd0);
        checkOutput("readyLatency", edgeNo - cur.start, cur.readyLat);
        checkOutput("dRdOe", {31'd0, oeV[inst]}, {31'd0, !cur.we});
        if (!cur.we) checkOutput("dRd", dRd[inst], cur.rdata);
    endtask

    task automatic expectReadyHigh(input int inst, input int budget);
        int n = 0;
        int ticks = 0;
        while (readynV[inst] !== 1'b1 && n < budget) begin
            stepEdge();
            if (ceAtEdge) ticks++;
            n++;
        end
        checkOutput("readynHigh", {31'd0, readynV[inst]}, 32'd1);
        checkOutput("readynLowTicks", ticks, 32'd1);
        checkOutput("dRdOeOff", {31'd0, oeV[inst]}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; a = '0; dWr = '0; ben = '0; st = '0; rw = 1'b1;
        ack = 2'b00; rData = '0;
        idleBus();
        repeat (3) stepEdge();
        rst = 1'b0;

        checkOutput("rstReadyn", {30'd0, readynV}, 32'd3);
        checkOutput("rstOe", {30'd0, oeV}, 32'd0);
        checkOutput("rstReq", {30'd0, memReqV}, 32'd0);
        checkOutput("rstDRd", dRd[0], 32'd0);
        checkOutput("rstMemA", {2'b00, memA[1]}, 32'd0);
        checkOutput("rstWe", {30'd0, memWeV}, 32'd0);

        // Plain read, no wait states, memory acknowledges immediately.
        ack = 2'b01; rData = 32'hDEAD_BEEF;
        applyStimulus(32'h0700_0010, 1'b1, 32'h0, 4'b1111, 2'b01, 1'b0);
        pushExpect(32'h0700_0010, 1'b0, 32'h0, 4'b1111, 2'b01, 32'hDEAD_BEEF, 1, 3);
        stepEdge(); idleBus();
        expectReq(0, 10);
        expectReadyLow(0, 10);
        expectReadyHigh(0, 10);

        // Write to the second instance with two wait states.
        ack = 2'b10;
        applyStimulus(32'h0800_0040, 1'b0, 32'h1234_5678, 4'b0011, 2'b10, 1'b0);
        pushExpect(32'h0800_0040, 1'b1, 32'h1234_5678, 4'b0011, 2'b10, 32'h0, 3, 5);
        stepEdge(); idleBus();
        expectReq(1, 20);
        checkOutput("otherQuiet", {30'd0, memReqV[0], readynV[0]}, 32'd1);
        expectReadyLow(1, 20);
        expectReadyHigh(1, 20);

        // Unselected address, then selected address with MRQN high.
        applyStimulus(32'h0500_0000, 1'b1, 32'h0, 4'b1111, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            stepEdge();
            idleBus();
            checkOutput("unselIdle", {28'd0, memReqV, readynV}, 32'h3);
        end
        applyStimulus(32'h0700_0000, 1'b1, 32'h0, 4'b1111, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            stepEdge();
            idleBus();
            checkOutput("mrqnIdle", {28'd0, memReqV, readynV}, 32'h3);
        end

        // Back-to-back reads: second cycle presented in the READYN-low (RDY) tick.
        ack = 2'b01; rData = 32'h1111_2222;
        applyStimulus(32'h0700_0100, 1'b1, 32'h0, 4'b1111, 2'b00, 1'b0);
        pushExpect(32'h0700_0100, 1'b0, 32'h0, 4'b1111, 2'b00, 32'h1111_2222, 1, 3);
        stepEdge(); idleBus();
        expectReq(0, 10);
        expectReadyLow(0, 10);
        rData = 32'h3333_4444;
        applyStimulus(32'h0700_0200, 1'b1, 32'h0, 4'b0101, 2'b01, 1'b0);
        pushExpect(32'h0700_0200, 1'b0, 32'h0, 4'b0101, 2'b01, 32'h3333_4444, 1, 3);
        expectReadyHigh(0, 10);
        idleBus();
        expectReq(0, 10);
        expectReadyLow(0, 10);
        expectReadyHigh(0, 10);

        // CE toggling, ACK five clocks after the request, stray BCYSTN during ACCESS.
        ack = 2'b00; rData = 32'hCAFE_F00D; ce = 1'b1; ceToggle = 1'b1;
        applyStimulus(32'h0700_0400, 1'b1, 32'h0, 4'b1111, 2'b11, 1'b0);
        pushExpect(32'h0700_0400, 1'b0, 32'h0, 4'b1111, 2'b11, 32'hCAFE_F00D, 2, 8);
        stepEdge(); idleBus();
        expectReq(0, 10);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) applyStimulus(32'h0700_0300, 1'b1, 32'h0, 4'b0001, 2'b00, 1'b0);
            if (i == 5) ack[0] = 1'b1;
            stepEdge();
            idleBus();
        end
        ack[0] = 1'b0;
        checkOutput("reqDropOnAck", {31'd0, memReqV[0]}, 32'd0);
        checkOutput("readynHeldOnAck", {31'd0, readynV[0]}, 32'd1);
        checkOutput("memAHeld", {2'b00, memA[0]}, {2'b00, 30'h01C0_0100});
        expectReadyLow(0, 10);
        expectReadyHigh(0, 10);
        ceToggle = 1'b0; ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepEdge();
            checkOutput("strayIgnored", {31'd0, memReqV[0]}, 32'd0);
        end

        // Reset while the memory request is outstanding; stale ACK afterwards.
        ack = 2'b00;
        applyStimulus(32'h0700_0030, 1'b1, 32'h0, 4'b1111, 2'b00, 1'b0);
        pushExpect(32'h0700_0030, 1'b0, 32'h0, 4'b1111, 2'b00, 32'h0, 1, 3);
        stepEdge(); idleBus();
        expectReq(0, 10);
        #3 rst = 1'b1;
        #1;
        checkOutput("rstMidReq", {31'd0, memReqV[0]}, 32'd0);
        checkOutput("rstMidReadyn", {31'd0, readynV[0]}, 32'd1);
        checkOutput("rstMidMemA", {2'b00, memA[0]}, 32'd0);
        #2 rst = 1'b0;
        ack = 2'b01;
        repeat (2) stepEdge();
        checkOutput("staleAckIgnored", {30'd0, memReqV[0], readynV[0]}, 32'd1);

        rData = 32'h5A5A_A5A5;
        applyStimulus(32'h0700_0020, 1'b1, 32'h0, 4'b1100, 2'b01, 1'b0);
        pushExpect(32'h0700_0020, 1'b0, 32'h0, 4'b1100, 2'b01, 32'h5A5A_A5A5, 1, 3);
        stepEdge(); idleBus();
        expectReq(0, 10);
        expectReadyLow(0, 10);
        expectReadyHigh(0, 10);

        checkOutput("sbDrained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
